// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores over a req/ack bus.
// Ports: i_dmem_* from memory stage, o_dmem_rdata/o_stall/o_fault back, o_bus_*/i_bus_* to memory bus.
module dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic        i_dmem_write,
  input  logic        i_dmem_read,
  input  logic        i_dmem_rdu,
  input  logic        i_dmem_byte,
  input  logic        i_dmem_hwrd,
  output logic [31:0] o_dmem_rdata,
  output logic        o_stall,
  output logic        o_fault,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [29:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        rdu_q;
  logic        byte_q;
  logic        hwrd_q;
  logic [CW-1:0] cnt;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic        mis;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [31:0] ld_fmt;

  assign access = i_dmem_read | i_dmem_write;
  assign sz_b   = i_dmem_byte;
  assign sz_h   = ~i_dmem_byte & i_dmem_hwrd;
  assign sz_w   = ~i_dmem_byte & ~i_dmem_hwrd;
  assign mis    = access & ((sz_h & i_dmem_addr[0]) |
                            (sz_w & (|i_dmem_addr[1:0])));

  // Loads fetch the full word; lane selection happens on the way back.
  always_comb begin
    be_in = 4'b1111;
    wd_in = i_dmem_wdata;
    unique case (1'b1)
      sz_b: begin
        wd_in = {4{i_dmem_wdata[7:0]}};
        if (i_dmem_write) be_in = 4'b0001 << i_dmem_addr[1:0];
      end
      sz_h: begin
        wd_in = {2{i_dmem_wdata[15:0]}};
        if (i_dmem_write) be_in = i_dmem_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    ld_b   = i_bus_rdata[{off_q, 3'b000} +: 8];
    ld_h   = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    ld_fmt = i_bus_rdata;
    if (byte_q)
      ld_fmt = {{24{~rdu_q & ld_b[7]}}, ld_b};
    else if (hwrd_q)
      ld_fmt = {{16{~rdu_q & ld_h[15]}}, ld_h};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdu_q   <= 1'b0;
      byte_q  <= 1'b0;
      hwrd_q  <= 1'b0;
      cnt     <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && !mis) begin
            addr_q  <= i_dmem_addr[31:2];
            off_q   <= i_dmem_addr[1:0];
            be_q    <= be_in;
            wdata_q <= wd_in;
            we_q    <= i_dmem_write;
            rdu_q   <= i_dmem_rdu;
            byte_q  <= i_dmem_byte;
            hwrd_q  <= i_dmem_hwrd;
            cnt     <= '0;
            fault_q <= 1'b0;
            state   <= BUS;
          end else if (mis) begin
            rdata_q <= '0;
          end
        end
        BUS: begin
          if (i_bus_ack) begin
            // Stores hand back the raw bus word; the stage ignores it.
            rdata_q <= we_q ? i_bus_rdata : ld_fmt;
            fault_q <= 1'b0;
            cnt     <= '0;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            rdata_q <= '0;
            fault_q <= 1'b1;
            cnt     <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic in_bus;
  logic in_idle;

  assign in_bus  = (state == BUS);
  assign in_idle = (state == IDLE);

  assign o_bus_req    = in_bus;
  assign o_bus_we     = in_bus & we_q;
  assign o_bus_addr   = in_bus ? addr_q : '0;
  assign o_bus_be     = in_bus ? be_q : '0;
  assign o_bus_wdata  = in_bus ? wdata_q : '0;
  assign o_stall      = in_bus | (in_idle & access & ~mis);
  assign o_fault      = (in_idle & mis) | ((state == DONE) & fault_q);
  assign o_dmem_rdata = (in_idle & mis) ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, reset corner, random vs model.
// Drives at negedge, samples at negedge; TIMEOUT_CYCLES set to 4.
module tb_dmem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic        rdu;
  logic        byt;
  logic        hwrd;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        req;
  logic        we;
  logic [29:0] baddr;
  logic [3:0]  be;
  logic [31:0] bwdata;
  logic        ack;
  logic [31:0] brdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_dmem_addr(addr), .i_dmem_wdata(wdata),
    .i_dmem_write(wr), .i_dmem_read(rd), .i_dmem_rdu(rdu),
    .i_dmem_byte(byt), .i_dmem_hwrd(hwrd),
    .o_dmem_rdata(rdata), .o_stall(stall), .o_fault(fault),
    .o_bus_req(req), .o_bus_we(we), .o_bus_addr(baddr),
    .o_bus_be(be), .o_bus_wdata(bwdata),
    .i_bus_ack(ack), .i_bus_rdata(brdata)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr();
    addr = '0; wdata = '0; wr = 0; rd = 0;
    rdu = 0; byt = 0; hwrd = 0; ack = 0; brdata = '0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        wr;
    logic        rd;
    logic        rdu;
    logic        b;
    logic        h;
    logic [31:0] brd;
    int          w;
    logic [3:0]  be;
    logic [31:0] ewd;
    logic [31:0] erd;
    int          st;
    logic        flt;
    logic        mis;
  } vec_t;

  // Reference: sizes, lanes and extension from plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    int     sz;
    int     off;
    longint mask;
    longint lane;
    sz  = v.b ? 1 : (v.h ? 2 : 4);
    off = int'(v.a % 4);
    mask = (longint'(1) << (8 * sz)) - 1;
    r.mis = (v.wr || v.rd) && (off % sz != 0);
    r.flt = r.mis;
    r.erd = 0;
    r.st  = 0;
    r.ewd = (sz == 1) ? v.wd[7:0] * 32'h01010101 :
            (sz == 2) ? v.wd[15:0] * 32'h00010001 : v.wd;
    if (!v.wr) r.be = 4'hF;
    else r.be = 4'((mask >> 0) & ((1 << sz) - 1)) << (sz == 4 ? 0 : off);
    if (!r.mis) begin
      lane = (longint'(v.brd) >> (8 * off)) & mask;
      if (sz < 4 && !v.rdu && lane >= (mask + 1) / 2)
        lane = lane - (mask + 1);
      if (v.w >= TO) begin
        r.flt = 1; r.erd = 0; r.st = 1 + TO;
      end else begin
        r.st  = v.w + 2;
        r.erd = v.wr ? v.brd : 32'(lane);
      end
    end
    return r;
  endfunction

  task automatic run(input string nm, input vec_t v);
    int  stalls;
    bit  first;
    bit  done;
    @(negedge clk);
    addr = v.a; wdata = v.wd; wr = v.wr; rd = v.rd;
    rdu = v.rdu; byt = v.b; hwrd = v.h; ack = 0; brdata = '0;
    #1;
    if (v.mis) begin
      chk({nm, " mis fault"}, 32'(fault), 1);
      chk({nm, " mis stall"}, 32'(stall), 0);
      chk({nm, " mis rdata"}, rdata, 0);
      chk({nm, " mis req"}, 32'(req), 0);
      @(negedge clk);
      clr();
      #1;
      chk({nm, " mis req after"}, 32'(req), 0);
      chk({nm, " mis fault after"}, 32'(fault), 0);
      return;
    end
    chk({nm, " idle stall"}, 32'(stall), 1);
    stalls = 1; first = 1; done = 0;
    for (int c = 0; c < TO + 3 && !done; c++) begin
      @(negedge clk);
      if (req) begin
        stalls += int'(stall);
        if (first) begin
          chk({nm, " addr"}, 32'(baddr), v.a >> 2);
          chk({nm, " we"}, 32'(we), 32'(v.wr));
          chk({nm, " be"}, 32'(be), 32'(v.be));
          if (v.wr) chk({nm, " wdata"}, bwdata, v.ewd);
          first = 0;
        end
        ack    = (c == v.w);
        brdata = (c == v.w) ? v.brd : 32'hDEAD_BEEF;
      end else begin
        done = 1;
      end
    end
    if (!done) chk({nm, " bus budget expired"}, 0, 1);
    ack = 0;
    chk({nm, " done stall"}, 32'(stall), 0);
    chk({nm, " done fault"}, 32'(fault), 32'(v.flt));
    chk({nm, " done rdata"}, rdata, v.erd);
    chk({nm, " stall cycles"}, 32'(stalls), 32'(v.st));
    clr();
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    //        a      wd        wr rd rdu b h brd       w   be     ewd       erd       st flt mis
    tbl[0]  = '{32'h1003, 0, 0,1,0,1,0, 32'h80FFFF7F, 0, 4'hF, 0, 32'hFFFFFF80, 2, 0, 0};
    tbl[1]  = '{32'h22, 32'h1234ABCD, 1,0,0,0,1, 0, 3, 4'hC, 32'hABCDABCD, 0, 5, 0, 0};
    tbl[2]  = '{32'h2, 0, 0,1,1,0,1, 32'hBEEF0000, 0, 4'hF, 0, 32'h0000BEEF, 2, 0, 0};
    tbl[3]  = '{32'h2, 0, 0,1,0,0,1, 32'hBEEF0000, 0, 4'hF, 0, 32'hFFFFBEEF, 2, 0, 0};
    tbl[4]  = '{32'h6, 0, 0,1,0,0,0, 0, 0, 4'hF, 0, 0, 0, 1, 1};
    tbl[5]  = '{32'h100, 0, 0,1,0,0,0, 0, 99, 4'hF, 0, 0, 5, 1, 0};
    tbl[6]  = '{32'h104, 0, 0,1,0,0,0, 32'hCAFEF00D, 1, 4'hF, 0, 32'hCAFEF00D, 3, 0, 0};
    tbl[7]  = '{32'h1, 32'h5A, 1,0,0,1,0, 32'h11111111, 0, 4'h2, 32'h5A5A5A5A, 32'h11111111, 2, 0, 0};
    tbl[8]  = '{32'h8, 32'h89ABCDEF, 1,1,0,0,0, 0, 0, 4'hF, 32'h89ABCDEF, 0, 2, 0, 0};
    tbl[9]  = '{32'h2, 0, 0,1,0,1,0, 32'h00A50000, 2, 4'hF, 0, 32'hFFFFFFA5, 4, 0, 0};
    tbl[10] = '{32'h23, 32'h1, 1,0,0,0,1, 0, 0, 4'hF, 0, 0, 0, 1, 1};
    tbl[11] = '{32'h3, 0, 0,1,1,1,1, 32'h7F000000, 0, 4'hF, 0, 32'h0000007F, 2, 0, 0};

    clr();
    rst = 1;
    repeat (2) @(negedge clk);
    chk("rst req", 32'(req), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst fault", 32'(fault), 0);
    chk("rst rdata", rdata, 0);
    chk("rst be", 32'(be), 0);
    chk("rst addr", 32'(baddr), 0);
    rst = 0;

    for (int i = 0; i < 12; i++)
      run($sformatf("vec%0d", i), tbl[i]);

    // Reset lands mid-transaction; a late ack must be ignored.
    @(negedge clk);
    addr = 32'h40; rd = 1;
    @(negedge clk);
    chk("rstmid req up", 32'(req), 1);
    @(negedge clk);
    rst = 1; clr();
    @(negedge clk);
    chk("rstmid req", 32'(req), 0);
    chk("rstmid stall", 32'(stall), 0);
    rst = 0; ack = 1; brdata = 32'h12345678;
    @(negedge clk);
    ack = 0;
    for (int k = 0; k < 2; k++) begin
      chk("rstmid late stall", 32'(stall), 0);
      chk("rstmid late fault", 32'(fault), 0);
      chk("rstmid late req", 32'(req), 0);
      chk("rstmid late rdata", rdata, 0);
      @(negedge clk);
    end
    run("after rst", tbl[6]);

    for (int n = 0; n < 80; n++) begin
      rv.a   = $urandom();
      rv.wd  = $urandom();
      rv.wr  = 1'($urandom_range(0, 1));
      rv.rd  = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.rdu = 1'($urandom_range(0, 1));
      rv.b   = 1'($urandom_range(0, 1));
      rv.h   = 1'($urandom_range(0, 1));
      rv.brd = $urandom();
      rv.w   = $urandom_range(0, 5);
      if ($urandom_range(0, 3) != 0) begin
        if (rv.b) rv.a[1:0] = 2'($urandom_range(0, 3));
        else if (rv.h) rv.a[0] = 1'b0;
        else rv.a[1:0] = 2'b00;
      end
      rv = model(rv);
      run($sformatf("rnd%0d", n), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
